// File: rtl/fir_output_buffer.sv
// FIR output decimator and show-ahead FIFO with ready/valid egress and clk_ena back-pressure.
// Optional popped-sample counter enabled by defining FIR_OBUF_CNT_EN.
module fir_output_buffer #(
    parameter int dw    = 18,
    parameter int DEPTH = 16,
    parameter int DECIM = 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fir_valid,
    input  logic signed [dw-1:0] fir_data,
    output logic                 fir_clk_ena,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [dw-1:0] m_data,
    output logic [AW:0]          level,
    output logic                 err_unexp,
    output logic [31:0]          sample_count
);

    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [dw-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [CW-1:0] decim_cnt_q, decim_cnt_d;
    logic          err_q, err_d;
    logic          full, acc, push, pop;

    assign full        = (level_q == (AW+1)'(DEPTH));
    assign fir_clk_ena = enable & ~full & ~reset;
    assign acc         = fir_valid & fir_clk_ena;
    assign push        = acc & (decim_cnt_q == '0);
    assign m_valid     = (level_q != '0);
    assign pop         = m_valid & m_ready;
    assign m_data      = mem_q[rd_ptr_q];
    assign level       = level_q;
    assign err_unexp   = err_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        decim_cnt_d = decim_cnt_q;
        err_d       = err_q;
        if (acc) begin
            if (decim_cnt_q == CW'(DECIM - 1)) decim_cnt_d = '0;
            else                               decim_cnt_d = decim_cnt_q + CW'(1);
        end
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        // A filter that is frozen must not present a sample
        if (fir_valid & ~fir_clk_ena) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            decim_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            decim_cnt_q <= decim_cnt_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= fir_data;
    end

`ifdef FIR_OBUF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pop) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign sample_count = cnt_q;
`else
    assign sample_count = 32'd0;
`endif

endmodule

// File: tb/tb_fir_output_buffer.sv
// Bench for fir_output_buffer: two instances (DECIM=1/DEPTH=16 and DECIM=3/DEPTH=4)
// checked every cycle against queue-based reference models.
module tb_fir_output_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, enable, m_ready, fv0, fv1;
    logic signed [17:0] fd;

    logic               ena0, mv0, err0;
    logic signed [17:0] md0;
    logic [4:0]         lvl0;
    logic [31:0]        sc0;
    logic               ena1, mv1, err1;
    logic signed [17:0] md1;
    logic [2:0]         lvl1;
    logic [31:0]        sc1;

    fir_output_buffer #(.dw(18), .DEPTH(16), .DECIM(1)) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable),
        .fir_valid(fv0), .fir_data(fd), .fir_clk_ena(ena0),
        .m_valid(mv0), .m_ready(m_ready), .m_data(md0),
        .level(lvl0), .err_unexp(err0), .sample_count(sc0)
    );

    fir_output_buffer #(.dw(18), .DEPTH(4), .DECIM(3)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable),
        .fir_valid(fv1), .fir_data(fd), .fir_clk_ena(ena1),
        .m_valid(mv1), .m_ready(m_ready), .m_data(md1),
        .level(lvl1), .err_unexp(err1), .sample_count(sc1)
    );

    int nerr = 0;
    int nchk = 0;

    logic signed [17:0] q0[$];
    logic signed [17:0] q1[$];
    int          dc0, dc1;
    bit          e0, e1;
    logic [31:0] c0, c1;
    bit          acc0_last;

    function automatic logic [31:0] cexp(logic [31:0] c);
`ifdef FIR_OBUF_CNT_EN
        return c;
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(bit en, bit f0req, bit f1req, bit force_v,
                        logic signed [17:0] d, bit rdy, bit rst);
        bit x0, x1, a0, a1, p0, p1;
        @(negedge clk);
        x0 = en && (q0.size() != 16) && !rst;
        x1 = en && (q1.size() != 4) && !rst;
        reset   = rst;
        enable  = en;
        m_ready = rdy;
        fd      = d;
        fv0     = force_v || (f0req && x0);
        fv1     = force_v || (f1req && x1);
        #1;
        chk("ena0", 64'(ena0), 64'(x0));
        chk("mvalid0", 64'(mv0), 64'(q0.size() != 0));
        chk("level0", 64'(lvl0), 64'(q0.size()));
        if (q0.size() != 0) chk("mdata0", 64'(md0), 64'(q0[0]));
        chk("err0", 64'(err0), 64'(e0));
        chk("count0", 64'(sc0), 64'(cexp(c0)));
        chk("ena1", 64'(ena1), 64'(x1));
        chk("mvalid1", 64'(mv1), 64'(q1.size() != 0));
        chk("level1", 64'(lvl1), 64'(q1.size()));
        if (q1.size() != 0) chk("mdata1", 64'(md1), 64'(q1[0]));
        chk("err1", 64'(err1), 64'(e1));
        chk("count1", 64'(sc1), 64'(cexp(c1)));
        a0 = 0;
        if (rst) begin
            q0.delete(); q1.delete();
            dc0 = 0; dc1 = 0; e0 = 0; e1 = 0; c0 = 0; c1 = 0;
        end else begin
            a0 = fv0 && x0;
            a1 = fv1 && x1;
            if (fv0 && !x0) e0 = 1;
            if (fv1 && !x1) e1 = 1;
            p0 = (q0.size() != 0) && rdy;
            p1 = (q1.size() != 0) && rdy;
            if (p0) begin void'(q0.pop_front()); c0++; end
            if (p1) begin void'(q1.pop_front()); c1++; end
            if (a0 && dc0 == 0) q0.push_back(d);
            if (a1 && dc1 == 0) q1.push_back(d);
            if (a0) dc0 = (dc0 + 1) % 1;
            if (a1) dc1 = (dc1 + 1) % 3;
        end
        acc0_last = a0;
    endtask

    initial begin
        int idx;
        reset = 1; enable = 0; m_ready = 0; fv0 = 0; fv1 = 0; fd = '0;
        dc0 = 0; dc1 = 0; e0 = 0; e1 = 0; c0 = 0; c1 = 0; acc0_last = 0;
        repeat (2) @(posedge clk);
        step(0, 0, 0, 0, 18'sd0, 0, 1);
        step(1, 0, 0, 0, 18'sd0, 1, 0);

        // Pass-through of three samples with the sink always ready
        step(1, 1, 1, 0, 18'sd5, 1, 0);
        step(1, 1, 1, 0, -18'sd3, 1, 0);
        step(1, 1, 1, 0, 18'sd7, 1, 0);
        repeat (3) step(1, 0, 0, 0, 18'sd0, 1, 0);

        // Fill to full with the sink stalled, then drain: 20 samples in order
        step(0, 0, 0, 0, 18'sd0, 0, 1);
        idx = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            step(1, idx < 20, idx < 20, 0, 18'(idx), cyc >= 30, 0);
            if (acc0_last) idx++;
        end

        // Decimation by 3 on inputs 0..8
        step(0, 0, 0, 0, 18'sd0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 1, 1, 0, 18'(i), 1, 0);
        repeat (4) step(1, 0, 0, 0, 18'sd0, 1, 0);

        // Unexpected valid while frozen sets the sticky error
        step(0, 0, 0, 1, 18'sd99, 1, 0);
        repeat (4) step(1, 1, 1, 0, 18'sd11, 1, 0);
        step(0, 0, 0, 0, 18'sd0, 1, 1);
        step(1, 0, 0, 0, 18'sd0, 1, 0);

        // Reset with a partially filled FIFO, then a fresh head sample
        for (int i = 0; i < 7; i++) step(1, 1, 1, 0, 18'(100 + i), 0, 0);
        step(1, 0, 0, 0, 18'sd0, 0, 1);
        step(1, 1, 1, 0, -18'sd42, 0, 0);
        repeat (2) step(1, 0, 0, 0, 18'sd0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, 0, 18'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
        repeat (10) step(1, 0, 0, 0, 18'sd0, 1, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
